// File: rtl/kia2_pkg.sv
// kia2_pkg: register map, STAT bit positions, receiver states and a count saturation helper
package kia2_pkg;
    localparam logic [1:0] A_STAT  = 2'd0;
    localparam logic [1:0] A_DATA  = 2'd1;
    localparam logic [1:0] A_COUNT = 2'd2;
    localparam int S_EMPTY = 0;
    localparam int S_FULL  = 1;
    localparam int S_OVR   = 2;
    localparam int S_PERR  = 3;
    localparam int S_FERR  = 4;
    localparam int S_IE    = 5;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    function automatic logic [7:0] sat8(input int unsigned v);
        return (v > 32'd255) ? 8'hFF : 8'(v);
    endfunction
endpackage

// File: rtl/kia2_if.sv
// kia2_if: 8-bit Wishbone-style slave bus with master/slave views
interface kia2_if;
    logic [1:0] ADR_I;
    logic       WE_I;
    logic       CYC_I;
    logic       STB_I;
    logic [7:0] DAT_I;
    logic       ACK_O;
    logic [7:0] DAT_O;
    modport master (output ADR_I, WE_I, CYC_I, STB_I, DAT_I, input ACK_O, DAT_O);
    modport slave  (input ADR_I, WE_I, CYC_I, STB_I, DAT_I, output ACK_O, DAT_O);
endinterface

// File: rtl/kia2_ps2_rx.sv
// kia2_ps2_rx: PS/2 device-to-host frame receiver with timeout; odd parity checked only with KIA2_PARITY_EN
module kia2_ps2_rx
    import kia2_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       c_i,
    input  logic       d_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       perr_o,
    output logic       ferr_o
);
`ifdef KIA2_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    localparam int TW = $clog2(TIMEOUT + 1);
    rx_state_e     state_q, state_d;
    logic [1:0]    c_s_q, d_s_q;
    logic          c_prev_q, ev, d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          bad_q, bad_d, tmo;
    logic [TW-1:0] to_q, to_d;

    assign ev     = c_prev_q & ~c_s_q[1];
    assign d      = d_s_q[1];
    assign tmo    = (state_q != RX_IDLE) && !ev && (to_q == TW'(TIMEOUT - 1));
    assign byte_o = sh_q;

    // synchronisers, edge history and receiver state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_s_q    <= 2'b11;
            d_s_q    <= 2'b11;
            c_prev_q <= 1'b1;
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            bad_q    <= 1'b0;
            to_q     <= '0;
        end else begin
            c_s_q    <= {c_s_q[0], c_i};
            d_s_q    <= {d_s_q[0], d_i};
            c_prev_q <= c_s_q[1];
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            bad_q    <= bad_d;
            to_q     <= to_d;
        end
    end

    // frame sequencing on PS/2 clock falling edges; parity verdict is taken at the parity bit
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        bad_d        = bad_q;
        to_d         = (state_q == RX_IDLE || ev) ? '0 : to_q + TW'(1);
        byte_valid_o = 1'b0;
        perr_o       = 1'b0;
        ferr_o       = 1'b0;
        if (tmo) begin
            state_d = RX_IDLE;
            to_d    = '0;
            ferr_o  = 1'b1;
        end else if (ev) begin
            case (state_q)
                RX_IDLE: begin
                    state_d = d ? RX_IDLE : RX_DATA;
                    cnt_d   = '0;
                end
                RX_DATA: begin
                    sh_d    = {d, sh_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'd7) ? RX_PARITY : RX_DATA;
                end
                RX_PARITY: begin
                    bad_d   = PAR_EN & ~^{sh_q, d};
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d      = RX_IDLE;
                    ferr_o       = ~d;
                    perr_o       = d & bad_q;
                    byte_valid_o = d & ~bad_q;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/kia2.sv
// kia2: PS/2 keyboard adapter with byte FIFO, error flags and interrupt; parity check enabled by KIA2_PARITY_EN
module kia2
    import kia2_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic  CLK_I,
    input  logic  RES_I,
    kia2_if.slave bus,
    input  logic  D_I,
    input  logic  C_I,
    output logic  INT_O
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    mem_q [DEPTH];
    logic          ack_q, int_q, ie_q, ie_d, ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;
    logic          empty, full, acc, wr, stat_wr, pop, flush, push;
    logic          rx_valid, rx_perr, rx_ferr, unused_dat;
    logic [7:0]    rx_byte, stat, rdata;

    kia2_ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk_i       (CLK_I),
        .rst_ni      (RES_I),
        .c_i         (C_I),
        .d_i         (D_I),
        .byte_valid_o(rx_valid),
        .byte_o      (rx_byte),
        .perr_o      (rx_perr),
        .ferr_o      (rx_ferr)
    );

    assign unused_dat = ^{bus.DAT_I[7:6], bus.DAT_I[1:0]};
    assign bus.ACK_O  = ack_q;
    assign bus.DAT_O  = ack_q ? rdata : 8'h00;
    assign INT_O      = int_q;

    // bus decode acts in the ACK cycle; flush beats push, and a pop frees room for a same-cycle push
    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == (AW+1)'(DEPTH));
        acc     = ack_q & bus.CYC_I & bus.STB_I;
        wr      = acc & bus.WE_I;
        stat_wr = wr && (bus.ADR_I == A_STAT);
        pop     = wr && (bus.ADR_I == A_DATA) && !empty;
        flush   = wr && (bus.ADR_I == A_COUNT);
        push    = rx_valid & ~flush & (~full | pop);
        wp_d    = flush ? wp_q : wp_q + AW'(push);
        rp_d    = flush ? wp_q : rp_q + AW'(pop);
        cnt_d   = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovr_d   = (rx_valid & ~flush & full & ~pop) | (ovr_q & ~(stat_wr & bus.DAT_I[S_OVR]));
        perr_d  = rx_perr | (perr_q & ~(stat_wr & bus.DAT_I[S_PERR]));
        ferr_d  = rx_ferr | (ferr_q & ~(stat_wr & bus.DAT_I[S_FERR]));
        ie_d    = stat_wr ? bus.DAT_I[S_IE] : ie_q;
        stat    = {2'b00, ie_q, ferr_q, perr_q, ovr_q, full, empty};
        rdata   = (bus.ADR_I == A_STAT)  ? stat :
                  (bus.ADR_I == A_DATA)  ? (empty ? 8'h00 : mem_q[rp_q]) :
                  (bus.ADR_I == A_COUNT) ? sat8(32'(cnt_q)) : 8'h00;
    end

    // acknowledge, FIFO storage and pointers, sticky flags, interrupt
    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            ack_q  <= 1'b0;
            int_q  <= 1'b0;
            ie_q   <= 1'b0;
            ovr_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            rp_q   <= '0;
            wp_q   <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            ack_q  <= bus.CYC_I & bus.STB_I & ~ack_q;
            int_q  <= ie_q & ~empty;
            ie_q   <= ie_d;
            ovr_q  <= ovr_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            rp_q   <= rp_d;
            wp_q   <= wp_d;
            cnt_q  <= cnt_d;
            if (push) mem_q[wp_q] <= rx_byte;
        end
    end
endmodule

// File: tb/tb_kia2.sv
// tb_kia2: directed PS/2 frames and bus accesses; expected read data queued and checked by a monitor
module tb_kia2;
    localparam int TMO = 4096;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d = 1'b1;
    logic c = 1'b1;
    logic int_o;
    logic [7:0] exp_q[$];
    string name_q[$];
    int total = 0;
    int bad = 0;

    kia2_if bus();
    kia2 #(.DEPTH(16), .TIMEOUT(TMO)) dut (
        .CLK_I(clk), .RES_I(rst_n), .bus(bus), .D_I(d), .C_I(c), .INT_O(int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [7:0] act, input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", n, act, expv);
        end
    endtask

    // read-data monitor
    always @(negedge clk) begin
        if (rst_n && bus.ACK_O && !bus.WE_I) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got %02h expected none", bus.DAT_O);
            end else begin
                check(name_q.pop_front(), bus.DAT_O, exp_q.pop_front());
            end
        end
    end

    task automatic xfer(input logic [1:0] a, input logic w, input logic [7:0] v);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.ADR_I = a; bus.WE_I = w; bus.DAT_I = v; bus.CYC_I = 1'b1; bus.STB_I = 1'b1;
        @(negedge clk);
        while (!bus.ACK_O && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ACK_O) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no ACK expected ACK within 10 cycles");
        end
        @(posedge clk);
        #1;
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        xfer(a, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        xfer(a, 1'b1, v);
    endtask

    task automatic ps2(input logic [7:0] b, input int nbits, input logic flip_par, input logic stop);
        logic [10:0] f;
        f = {stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            d = f[i];
            repeat (8) @(posedge clk);
            #1 c = 1'b0;
            repeat (8) @(posedge clk);
            #1 c = 1'b1;
        end
        d = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ADR_I = 2'd0; bus.WE_I = 1'b0; bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.DAT_I = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {7'b0, bus.ACK_O}, 8'h00);
        check("rst_int", {7'b0, int_o}, 8'h00);
        check("rst_dat", bus.DAT_O, 8'h00);
        rst_n = 1'b1;
        rd(2'd0, 8'h01, "rst_stat");
        rd(2'd2, 8'h00, "rst_count");
        // single good frame
        ps2(8'h1C, 11, 1'b0, 1'b1);
        rd(2'd0, 8'h00, "t1_stat");
        rd(2'd2, 8'h01, "t1_count");
        rd(2'd1, 8'h1C, "t1_data");
        wr(2'd1, 8'h00);
        rd(2'd0, 8'h01, "t1_stat_empty");
        // fill to true full, then overrun
        for (int i = 0; i < 16; i++) ps2(8'(i), 11, 1'b0, 1'b1);
        ps2(8'h55, 11, 1'b0, 1'b1);
        rd(2'd2, 8'h10, "t2_count");
        rd(2'd0, 8'h06, "t2_stat");
        for (int i = 0; i < 16; i++) begin
            rd(2'd1, 8'(i), "t2_data");
            wr(2'd1, 8'h00);
        end
        rd(2'd0, 8'h05, "t2_stat_drained");
        wr(2'd0, 8'h04);
        rd(2'd0, 8'h01, "t2_ovr_cleared");
        // pop on empty and reserved register
        wr(2'd1, 8'h00);
        rd(2'd2, 8'h00, "pop_empty_count");
        rd(2'd1, 8'h00, "empty_data");
        rd(2'd3, 8'h00, "reserved_rd");
        wr(2'd3, 8'hFF);
        rd(2'd0, 8'h01, "reserved_wr");
        // bad stop bit
        ps2(8'h1C, 11, 1'b0, 1'b0);
        rd(2'd0, 8'h11, "t3_stat");
        rd(2'd2, 8'h00, "t3_count");
        wr(2'd0, 8'h10);
        rd(2'd0, 8'h01, "t3_cleared");
        // timeout after start + 4 data bits
        ps2(8'h0F, 5, 1'b0, 1'b1);
        repeat (TMO + 2) @(posedge clk);
        rd(2'd0, 8'h11, "t4_stat");
        rd(2'd2, 8'h00, "t4_count");
        wr(2'd0, 8'h10);
        ps2(8'h2A, 11, 1'b0, 1'b1);
        rd(2'd1, 8'h2A, "t4_data");
        wr(2'd1, 8'h00);
        rd(2'd0, 8'h01, "t4_stat_after");
        // interrupt
        wr(2'd0, 8'h20);
        rd(2'd0, 8'h21, "t5_stat_ie");
        check("t5_int_idle", {7'b0, int_o}, 8'h00);
        ps2(8'h33, 11, 1'b0, 1'b1);
        check("t5_int_set", {7'b0, int_o}, 8'h01);
        rd(2'd0, 8'h20, "t5_stat");
        wr(2'd1, 8'h00);
        check("t5_int_hold", {7'b0, int_o}, 8'h01);
        @(posedge clk);
        #1;
        check("t5_int_fall", {7'b0, int_o}, 8'h00);
        wr(2'd0, 8'h00);
        // flush
        ps2(8'h11, 11, 1'b0, 1'b1);
        ps2(8'h22, 11, 1'b0, 1'b1);
        rd(2'd2, 8'h02, "flush_pre");
        wr(2'd2, 8'h00);
        rd(2'd2, 8'h00, "flush_count");
        rd(2'd0, 8'h01, "flush_stat");
        // bad parity
        ps2(8'h1C, 11, 1'b1, 1'b1);
`ifdef KIA2_PARITY_EN
        rd(2'd0, 8'h09, "t6_stat_perr");
        rd(2'd2, 8'h00, "t6_count");
        wr(2'd0, 8'h08);
`else
        rd(2'd0, 8'h00, "t6_stat_noperr");
        rd(2'd2, 8'h01, "t6_count");
        rd(2'd1, 8'h1C, "t6_data");
        wr(2'd1, 8'h00);
        wr(2'd0, 8'h08);
`endif
        rd(2'd0, 8'h01, "t6_stat_after");
        // reset mid-frame
        wr(2'd0, 8'h20);
        ps2(8'h77, 11, 1'b0, 1'b1);
        check("rst2_int_pre", {7'b0, int_o}, 8'h01);
        ps2(8'h5A, 4, 1'b0, 1'b1);
        d = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst2_ack", {7'b0, bus.ACK_O}, 8'h00);
        check("rst2_int", {7'b0, int_o}, 8'h00);
        check("rst2_dat", bus.DAT_O, 8'h00);
        c = 1'b1;
        d = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(2'd0, 8'h01, "rst2_stat");
        rd(2'd2, 8'h00, "rst2_count");
        ps2(8'h5A, 11, 1'b0, 1'b1);
        rd(2'd1, 8'h5A, "rst2_data");
        rd(2'd2, 8'h01, "rst2_count_after");
        repeat (4) @(posedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
